// File: rtl/speed_gate_ctrl.sv
// Entry/exit sequencing for the speed-measuring parking gate: turns raw sensor
// edges into datapath command strobes and times the barrier hold.
module speed_gate_ctrl #(
    parameter int WIDTH_SPEED = 14,
    parameter int MAX_VEH     = 3,
    parameter int SPEED_LIMIT = 40,
    parameter int SYS_FREQ    = 50000000,
    parameter int TIMEOUT_MS  = 1000,
    parameter int HOLD_MS     = 2000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sen_in1,
    input  logic                   sen_in2,
    input  logic                   sen_out,
    input  logic [1:0]             num_veh,
    input  logic [WIDTH_SPEED-1:0] speed,
    input  logic                   done,
    output logic                   init,
    output logic                   count,
    output logic                   cal,
    output logic                   up,
    output logic                   down,
    output logic                   en,
    output logic                   dis,
    output logic                   full,
    output logic                   overspeed,
    output logic                   timeout
);

    // state    | meaning
    // IDLE     | waiting for an entry event on sensor A
    // TIMING   | ms timer running, waiting for sensor B or timeout
    // WAIT_DIV | divide in progress, waiting for done
    typedef enum logic [1:0] {IDLE, TIMING, WAIT_DIV} state_t;

    localparam int DIV    = SYS_FREQ / 1000;
    localparam int DIV_M1 = DIV - 1;
    localparam int PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HOLD_W = $clog2(HOLD_MS + 1);

    localparam logic [PRE_W-1:0]       PRE_LAST  = DIV_M1[PRE_W-1:0];
    localparam logic [9:0]             TIMEOUT_V = TIMEOUT_MS[9:0];
    localparam logic [HOLD_W-1:0]      HOLD_V    = HOLD_MS[HOLD_W-1:0];
    localparam logic [1:0]             MAX_V     = MAX_VEH[1:0];
    localparam logic [WIDTH_SPEED-1:0] LIMIT_V   = SPEED_LIMIT[WIDTH_SPEED-1:0];

    state_t             state_q, state_d;
    logic [2:0]         s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [9:0]         to_cnt_q, to_cnt_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               hold_act_q, hold_act_d;
    logic               init_q, init_d, count_q, count_d, cal_q, cal_d;
    logic               up_q, up_d, down_q, down_d, en_q, en_d, dis_q, dis_d;
    logic               ovs_q, ovs_d, to_q, to_d;
    logic [2:0]         evt;
    logic               ms_tick;

    // bit 0 = entry A, bit 1 = entry B, bit 2 = exit
    assign s1_d    = {sen_out, sen_in2, sen_in1};
    assign s2_d    = s1_q;
    assign s3_d    = s2_q;
    assign evt     = s2_q & ~s3_q;
    assign ms_tick = (pre_q == PRE_LAST);
    assign pre_d   = ms_tick ? '0 : pre_q + 1'b1;
    assign full    = (num_veh >= MAX_V);

    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        init_d   = 1'b0;
        cal_d    = 1'b0;
        up_d     = 1'b0;
        ovs_d    = 1'b0;
        to_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (evt[0] && !full) begin
                    init_d   = 1'b1;
                    to_cnt_d = '0;
                    state_d  = TIMING;
                end
            end
            TIMING: begin
                // B has priority over a timeout landing in the same cycle
                if (evt[1]) begin
                    cal_d   = 1'b1;
                    state_d = WAIT_DIV;
                end else if (to_cnt_q == TIMEOUT_V) begin
                    to_d    = 1'b1;
                    init_d  = 1'b1;
                    state_d = IDLE;
                end else if (ms_tick) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            WAIT_DIV: begin
                if (done) begin
                    if (speed > LIMIT_V) ovs_d = 1'b1;
                    else                 up_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        count_d = (state_d == TIMING);
    end

    always_comb begin
        down_d     = evt[2] && (num_veh != 2'd0);
        en_d       = down_d;
        hold_cnt_d = hold_cnt_q;
        hold_act_d = hold_act_q;
        dis_d      = 1'b0;
        // a fresh open always wins over an expiry in the same cycle
        if (up_d || en_d) begin
            hold_cnt_d = HOLD_V;
            hold_act_d = 1'b1;
        end else if (hold_act_q) begin
            if (hold_cnt_q == '0) begin
                dis_d      = 1'b1;
                hold_act_d = 1'b0;
            end else if (ms_tick) begin
                hold_cnt_d = hold_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            pre_q      <= '0;
            to_cnt_q   <= '0;
            hold_cnt_q <= '0;
            hold_act_q <= 1'b0;
            init_q     <= 1'b0;
            count_q    <= 1'b0;
            cal_q      <= 1'b0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            en_q       <= 1'b0;
            dis_q      <= 1'b0;
            ovs_q      <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            pre_q      <= pre_d;
            to_cnt_q   <= to_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            hold_act_q <= hold_act_d;
            init_q     <= init_d;
            count_q    <= count_d;
            cal_q      <= cal_d;
            up_q       <= up_d;
            down_q     <= down_d;
            en_q       <= en_d;
            dis_q      <= dis_d;
            ovs_q      <= ovs_d;
            to_q       <= to_d;
        end
    end

    assign init      = init_q;
    assign count     = count_q;
    assign cal       = cal_q;
    assign up        = up_q;
    assign down      = down_q;
    assign en        = en_q;
    assign dis       = dis_q;
    assign overspeed = ovs_q;
    assign timeout   = to_q;

endmodule

// File: tb/tb_speed_gate_ctrl.sv
// Directed bench for speed_gate_ctrl at 10 cycles per ms.
module tb_speed_gate_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sen_in1 = 1'b0, sen_in2 = 1'b0, sen_out = 1'b0;
    logic [1:0]  num_veh = 2'd0;
    logic [13:0] speed = 14'd0;
    logic        done = 1'b0;
    logic        init, count, cal, up, down, en, dis, full, overspeed, timeout;

    speed_gate_ctrl #(
        .WIDTH_SPEED(14), .MAX_VEH(3), .SPEED_LIMIT(40),
        .SYS_FREQ(10000), .TIMEOUT_MS(1000), .HOLD_MS(2000)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .sen_in1(sen_in1), .sen_in2(sen_in2), .sen_out(sen_out),
        .num_veh(num_veh), .speed(speed), .done(done),
        .init(init), .count(count), .cal(cal), .up(up), .down(down),
        .en(en), .dis(dis), .full(full), .overspeed(overspeed), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // pulse indices: 0 init, 1 cal, 2 up, 3 down, 4 en, 5 dis, 6 overspeed, 7 timeout
    logic [7:0] cmd, prev_cmd = 8'd0;
    int pc [8];
    int last [8];
    int cyc = 0, count_cyc = 0, wviol = 0;
    int n_cmp = 0, n_err = 0;

    assign cmd = {timeout, overspeed, dis, en, down, up, cal, init};

    initial for (int i = 0; i < 8; i++) begin pc[i] = 0; last[i] = 0; end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (count) count_cyc <= count_cyc + 1;
        for (int i = 0; i < 8; i++) begin
            if (cmd[i]) begin
                pc[i]   <= pc[i] + 1;
                last[i] <= cyc + 1;
                if (prev_cmd[i]) wviol <= wviol + 1;
            end
        end
        prev_cmd <= cmd;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin @(negedge clk); #1; end
    endtask

    task automatic wait_for(input int idx, input int maxc);
        int base;
        base = pc[idx];
        for (int i = 0; i < maxc && pc[idx] == base; i++) begin @(negedge clk); #1; end
    endtask

    // A rise, B rise b_dly cycles later, done 14 cycles after cal; tc = cal cycle
    task automatic run_entry(input int b_dly, input logic [13:0] spd,
                             input bit with_exit, output int tc);
        int t0, tb, c0;
        t0 = cyc; c0 = count_cyc;
        sen_in1 = 1'b1;
        wait_for(0, 20);
        chk("init_latency", last[0] - t0, 3);
        chk("count_high", int'(count), 1);
        step(5); sen_in1 = 1'b0;
        wait_until(t0 + b_dly);
        tb = cyc;
        sen_in2 = 1'b1;
        wait_for(1, 20);
        tc = last[1];
        chk("cal_latency", tc - tb, 3);
        chk("count_drop", int'(count), 0);
        chk("count_cycles", count_cyc - c0, b_dly);
        step(5); sen_in2 = 1'b0;
        if (with_exit) begin wait_until(tc + 12); sen_out = 1'b1; end
        wait_until(tc + 14);
        speed = spd; done = 1'b1;
        step(1);
        done = 1'b0;
    endtask

    initial begin
        int tc, t, d;
        step(3);
        chk("reset_outputs", int'({init, count, cal, up, down, en, dis, full, overspeed, timeout}), 0);
        reset_n = 1'b1;
        step(5);

        // overspeed: 20 ms, 720 km/h
        run_entry(200, 14'd720, 1'b0, tc);
        chk("ovs_time", last[6] - tc, 15);
        chk("ovs_count", pc[6], 1);
        chk("no_up_on_ovs", pc[2], 0);
        step(20);
        chk("no_dis_after_ovs", pc[5], 0);

        // admitted: 400 ms, 36 km/h, then barrier hold
        run_entry(4000, 14'd36, 1'b0, tc);
        chk("up_time", last[2] - tc, 15);
        chk("up_count", pc[2], 1);
        chk("ovs_unchanged", pc[6], 1);
        wait_for(5, 20100);
        chk("dis_count_1", pc[5], 1);
        d = last[5] - last[2];
        chk("dis_hold_window", int'(d >= 19990 && d <= 20005), 1);
        step(50);
        chk("dis_single_1", pc[5], 1);

        // timeout: B never arrives
        t = cyc; sen_in1 = 1'b1;
        wait_for(0, 20);
        chk("init_latency_to", last[0] - t, 3);
        t = last[0];
        step(5); sen_in1 = 1'b0;
        wait_for(7, 10100);
        chk("timeout_count", pc[7], 1);
        d = last[7] - t;
        chk("timeout_window", int'(d >= 9990 && d <= 10005), 1);
        chk("timeout_init_together", last[0], last[7]);
        chk("init_count_to", pc[0], 4);
        step(1);
        chk("count_after_timeout", int'(count), 0);

        // full: A ignored, exit opens barrier
        num_veh = 2'd3;
        step(1);
        chk("full_high", int'(full), 1);
        sen_in1 = 1'b1;
        step(15);
        sen_in1 = 1'b0;
        chk("no_init_when_full", pc[0], 4);
        chk("count_low_when_full", int'(count), 0);
        t = cyc; sen_out = 1'b1;
        wait_for(4, 20);
        chk("down_latency", last[3] - t, 3);
        chk("en_latency", last[4] - t, 3);
        step(5); sen_out = 1'b0;
        wait_for(5, 20100);
        chk("dis_count_2", pc[5], 2);
        d = last[5] - last[4];
        chk("dis_exit_window", int'(d >= 19990 && d <= 20005), 1);

        // empty: exit discarded
        num_veh = 2'd0;
        step(1);
        chk("full_low", int'(full), 0);
        sen_out = 1'b1;
        step(15);
        sen_out = 1'b0;
        chk("no_down_when_empty", pc[3], 1);
        chk("no_en_when_empty", pc[4], 1);
        step(5);

        // up and down in the same cycle
        num_veh = 2'd1;
        run_entry(100, 14'd40, 1'b1, tc);
        step(3); sen_out = 1'b0;
        chk("up_coincident", last[2] - tc, 15);
        chk("down_coincident", last[3] - tc, 15);
        chk("en_coincident", last[4] - tc, 15);
        chk("up_count_2", pc[2], 2);
        wait_for(5, 20100);
        chk("dis_count_3", pc[5], 3);
        d = last[5] - last[2];
        chk("dis_coincident_window", int'(d >= 19990 && d <= 20005), 1);
        step(50);
        chk("dis_single_3", pc[5], 3);

        // reset while timing
        t = cyc; sen_in1 = 1'b1;
        wait_for(0, 20);
        chk("init_count_pre_rst", pc[0], 6);
        step(2);
        chk("count_before_rst", int'(count), 1);
        sen_in1 = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("count_async_rst", int'(count), 0);
        step(2);
        chk("rst_outputs", int'({init, count, cal, up, down, en, dis, overspeed, timeout}), 0);
        reset_n = 1'b1;
        step(5);
        chk("post_rst_outputs", int'({init, count, cal, up, down, en, dis, overspeed, timeout}), 0);
        sen_in2 = 1'b1;
        step(15);
        sen_in2 = 1'b0;
        chk("b_ignored_idle", pc[1], 3);
        chk("count_idle_after_b", int'(count), 0);
        sen_in1 = 1'b1;
        wait_for(0, 20);
        sen_in1 = 1'b0;
        chk("init_after_rst", pc[0], 7);
        step(5);

        chk("pulse_width", wviol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/speed_gate_ctrl.md
Name: speed_gate_ctrl

Overview:
- Control FSM for the vehicle speed/parking gate datapath. It converts raw sensor inputs into the datapath's init/count/cal/up/down/en/dis command strobes.
- It consumes the datapath's speed, done and num_veh results to decide admission, overspeed denial and barrier timing.
- It sits between the sensor I/O pins and the datapath.

Parameters:
- WIDTH_SPEED, 14, width of the speed input, in km/h.
- MAX_VEH, 3, occupancy limit; must be less than 4 (num_veh is 2 bits).
- SPEED_LIMIT, 40, highest admissible speed in km/h.
- SYS_FREQ, 50000000, clk frequency in Hz; one ms tick every SYS_FREQ/1000 cycles.
- TIMEOUT_MS, 1000, maximum ms from sen_in1 to sen_in2; must be less than 1024.
- HOLD_MS, 2000, time the barrier stays open after the last up/en, in ms.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- sen_in1, input, 1, raw entry sensor A, active-high, asynchronous.
- sen_in2, input, 1, raw entry sensor B, downstream of A, asynchronous.
- sen_out, input, 1, raw exit sensor, asynchronous.
- num_veh, input, 2, current occupancy from the datapath.
- speed, input, WIDTH_SPEED, quotient from the datapath divider.
- done, input, 1, divider result valid.
- init, output, 1, one-cycle pulse; clears the datapath timers and divider.
- count, output, 1, level; the datapath ms timer runs while high.
- cal, output, 1, one-cycle pulse; starts the divide.
- up, output, 1, one-cycle pulse; admits a vehicle (num_veh+1, barrier open).
- down, output, 1, one-cycle pulse; a vehicle left (num_veh-1).
- en, output, 1, one-cycle pulse; opens the barrier for an exit.
- dis, output, 1, one-cycle pulse; closes the barrier.
- full, output, 1, high when num_veh is at least MAX_VEH.
- overspeed, output, 1, one-cycle pulse; the last measured speed exceeded SPEED_LIMIT.
- timeout, output, 1, one-cycle pulse; sen_in2 did not arrive within TIMEOUT_MS.

Behaviour:
- Reset is decided: reset_n is asynchronous and active-low; the clock is clk.
- All outputs reset to 0. The FSM resets to IDLE. Synchronisers, prescaler and ms counters reset to 0.
- Reset mid-operation aborts immediately; no dis is issued on reset.
- Inputs: each sensor passes through a 2-FF synchroniser and then a rising-edge detector. An event is a 1-cycle pulse, 3 cycles after the pin rises. Levels and falling edges are ignored.
- Timebase: the internal prescaler runs continuously from reset and produces ms_tick once every SYS_FREQ/1000 cycles.
- full is combinational: (num_veh >= MAX_VEH).
- Entry FSM, IDLE:
  - On an A event with full=0: pulse init, go to TIMING, clear the timeout counter.
  - On an A event with full=1: ignore it.
- Entry FSM, TIMING:
  - count=1 throughout; the timeout counter increments on each ms_tick.
  - On a B event: count drops the next cycle, cal pulses, go to WAIT_DIV.
  - Otherwise, when the timeout counter reaches TIMEOUT_MS: pulse timeout and init, go to IDLE.
  - If a B event and the timeout occur in the same cycle, the B event wins.
  - A events are ignored.
- Entry FSM, WAIT_DIV: wait for done=1, then go to IDLE.
  - If speed > SPEED_LIMIT: pulse overspeed; no up is issued.
  - If speed <= SPEED_LIMIT: pulse up.
  - A and B events are ignored in this state.
- A B event in IDLE or WAIT_DIV is ignored.
- Exit path, independent of the FSM:
  - On a sen_out event with num_veh != 0: pulse down and en in the same cycle.
  - On a sen_out event with num_veh == 0: discard it; no pulses.
  - down and up may pulse in the same cycle; the datapath nets these to no change.
- Barrier hold:
  - Any up or en pulse loads the hold counter with HOLD_MS and sets hold_active.
  - The hold counter decrements on each ms_tick.
  - When it reaches 0 with hold_active set: pulse dis, clear hold_active.
  - An up/en that coincides with expiry reloads the counter; dis is suppressed.
- Exactly one pulse per event. No command output is ever asserted for more than one cycle, except count.

Test Plan (SYS_FREQ=10000, i.e. 10 cycles/ms):
- A rises, B rises 20 ms later; model done after 14 cycles with speed=720 → init, then count high for about 200 cycles, then cal, then overspeed; no up; FSM returns to IDLE.
- Same stimulus with B 400 ms after A and speed=36 → up pulse; after 2000 ms (about 20000 cycles) with no further events, a single dis pulse.
- A rises, B never arrives, TIMEOUT_MS=1000 → timeout and init pulses about 10000 cycles after A; count=0 afterwards.
- num_veh=3 (full=1), A event → no init; full=1. Then sen_out event → down and en pulse together; a dis pulse HOLD_MS later.
- num_veh=0, sen_out event → no down, no en. Then up and down in the same cycle → both pulse, a single hold reload, one dis.
- reset_n asserted while in TIMING with count=1 → count=0 immediately, asynchronously; after release, IDLE with all outputs 0.
